// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and state encoding for the PS/2 key receiver
package ps2_pkg;

  // Receiver states; START is kept in the encoding even though the start bit
  // is consumed directly in IDLE.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } ps2_state_e;

  localparam int PS2_FRAME_BITS         = 11;
  localparam int DEFAULT_TIMEOUT_CYCLES = 50000;

endpackage

// File: rtl/key_fifo.sv
// rtl/key_fifo.sv - first-word-fall-through byte FIFO for received scan codes
module key_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             pop_ok;
  logic             push_ok;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  // A pop on an empty FIFO is ignored; a push into a full FIFO only succeeds
  // when a pop frees the head slot in the same cycle.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // Storage array; contents are only visible through dout when non-empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally at their width; count tracks occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_receiver.sv
// rtl/ps2_key_receiver.sv - PS/2 frame deserialiser feeding a scan-code FIFO
module ps2_key_receiver
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_rd,
  output logic [7:0] key_code,
  output logic       key_ready,
  output logic       overflow,
  output logic       parity_err,
  input  logic       err_clr
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);

  ps2_state_e  state;
  ps2_state_e  state_nxt;
  logic        clk_meta;
  logic        sync_clk;
  logic        sync_clk_d;
  logic        data_meta;
  logic        sync_data;
  logic        fall;
  logic [7:0]  sr;
  logic [2:0]  bit_cnt;
  logic        par;
  logic [TW-1:0] timer;
  logic        timed_out;
  logic        push;
  logic        err_set;
  logic        shift_en;
  logic        par_en;
  logic        clr_cnt;
  logic        fifo_empty;
  logic        fifo_full;
  logic        ovf_set;

  // Two-flop synchronisers plus one delay stage on the clock for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_meta   <= 1'b1;
      sync_clk   <= 1'b1;
      sync_clk_d <= 1'b1;
      data_meta  <= 1'b1;
      sync_data  <= 1'b1;
    end else begin
      clk_meta   <= ps2_clk;
      sync_clk   <= clk_meta;
      sync_clk_d <= sync_clk;
      data_meta  <= ps2_data;
      sync_data  <= data_meta;
    end
  end

  assign fall      = sync_clk_d & ~sync_clk;
  // A falling edge keeps the frame alive even on the cycle the timer expires.
  assign timed_out = (state != ST_IDLE) && !fall && (timer == TW'(TIMEOUT_CYCLES - 1));

  // Receiver state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state and per-edge control strobes.
  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    err_set   = 1'b0;
    shift_en  = 1'b0;
    par_en    = 1'b0;
    clr_cnt   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall && !sync_data) begin
          clr_cnt   = 1'b1;
          state_nxt = ST_DATA;
        end
      end
      ST_START: begin
        clr_cnt   = 1'b1;
        state_nxt = ST_DATA;
      end
      ST_DATA: begin
        if (fall) begin
          shift_en = 1'b1;
          if (bit_cnt == 3'd7) state_nxt = ST_PARITY;
        end
      end
      ST_PARITY: begin
        if (fall) begin
          par_en    = 1'b1;
          state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (fall) begin
          if (sync_data && ((^sr ^ par) == 1'b1)) push = 1'b1;
          else                                     err_set = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (timed_out) begin
      state_nxt = ST_IDLE;
      push      = 1'b0;
      err_set   = 1'b0;
      shift_en  = 1'b0;
      par_en    = 1'b0;
    end
  end

  // Shift register, bit counter, parity capture and inactivity timer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
      par     <= 1'b0;
      timer   <= '0;
    end else begin
      if (state == ST_IDLE || fall) timer <= '0;
      else                          timer <= timer + 1'b1;
      if (clr_cnt) bit_cnt <= '0;
      if (shift_en) begin
        sr      <= {sync_data, sr[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
      if (par_en) par <= sync_data;
    end
  end

  // With the FIFO full it is non-empty, so key_rd alone means a real pop.
  assign ovf_set = push & fifo_full & ~key_rd;

  // Sticky error flags; a new error in the same cycle beats err_clr.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (err_set)      parity_err <= 1'b1;
      else if (err_clr) parity_err <= 1'b0;
      if (ovf_set)      overflow   <= 1'b1;
      else if (err_clr) overflow   <= 1'b0;
    end
  end

  key_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (key_rd),
    .din   (sr),
    .dout  (key_code),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign key_ready = ~fifo_empty;

endmodule
